// File: rtl/cbrt_arbiter_if.sv
// Handshake bundle between the requester-side clients, the cube-root arbiter
// and the shared cube-root core.
interface cbrt_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req_i;
    logic [8*N-1:0] x_bi;
    logic [N-1:0]   ack_o;
    logic           busy_o;
    logic           done_o;
    logic [IDW-1:0] done_id_o;
    logic [7:0]     y_bo;
    logic           err_o;
    logic           core_start_o;
    logic [7:0]     core_x_o;
    logic           core_busy_i;
    logic [7:0]     core_y_i;

    modport slave (
        input  req_i, x_bi, core_busy_i, core_y_i,
        output ack_o, busy_o, done_o, done_id_o, y_bo, err_o, core_start_o, core_x_o
    );

    modport master (
        output req_i, x_bi, core_busy_i, core_y_i,
        input  ack_o, busy_o, done_o, done_id_o, y_bo, err_o, core_start_o, core_x_o
    );
endinterface

// File: rtl/cbrt_arbiter.sv
// Round-robin arbiter that shares one iterative 8-bit cube-root core between
// N requesters, with a watchdog that aborts a hung core.
module cbrt_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    cbrt_arbiter_if.slave bus
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_id;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] grant_id;
    logic           grant_vld;
    logic [WDW-1:0] wdog;
    logic [WDW-1:0] wdog_nxt;
    logic           wd_expired;

    assign wdog_nxt   = wdog + 1'b1;
    assign wd_expired = (wdog_nxt == WDW'(TIMEOUT));

    // Walk offsets from far to near so the nearest requester after last_id wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last_id) + i) % N;
            if (bus.req_i[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    // The acknowledge must land in the grant cycle itself, so it is decoded
    // from the registered state rather than registered again.
    always_comb begin
        bus.ack_o = '0;
        if (state == IDLE && grant_vld) begin
            bus.ack_o[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            last_id          <= IDW'(N - 1);
            cur_id           <= '0;
            wdog             <= '0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.done_id_o    <= '0;
            bus.y_bo         <= '0;
            bus.err_o        <= 1'b0;
            bus.core_start_o <= 1'b0;
            bus.core_x_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        bus.core_x_o     <= bus.x_bi[8*int'(grant_id) +: 8];
                        cur_id           <= grant_id;
                        last_id          <= grant_id;
                        bus.core_start_o <= 1'b1;
                        bus.busy_o       <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.core_start_o <= 1'b0;
                    wdog             <= '0;
                    state            <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    wdog <= wdog_nxt;
                    if (wd_expired) begin
                        bus.y_bo      <= '0;
                        bus.err_o     <= 1'b1;
                        bus.done_o    <= 1'b1;
                        bus.done_id_o <= cur_id;
                        state         <= RESULT;
                    end else if (bus.core_busy_i) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    wdog <= wdog_nxt;
                    // Watchdog wins even if the core finishes in the same cycle.
                    if (wd_expired) begin
                        bus.y_bo      <= '0;
                        bus.err_o     <= 1'b1;
                        bus.done_o    <= 1'b1;
                        bus.done_id_o <= cur_id;
                        state         <= RESULT;
                    end else if (!bus.core_busy_i) begin
                        bus.y_bo      <= bus.core_y_i;
                        bus.err_o     <= 1'b0;
                        bus.done_o    <= 1'b1;
                        bus.done_id_o <= cur_id;
                        state         <= RESULT;
                    end
                end
                RESULT: begin
                    bus.done_o <= 1'b0;
                    bus.err_o  <= 1'b0;
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cbrt_arbiter.sv
// Self-checking bench for cbrt_arbiter: directed vector table, hand-written
// reset sequence, and randomized transactions against a transaction-level model.
module tb_cbrt_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cbrt_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    cbrt_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int last_m;
    logic [7:0]     prev_y;
    logic [IDW-1:0] prev_id;

    // Behavioural cube-root core: busy for core_len cycles after start, or
    // never busy when hung.
    int         core_len  = 1;
    bit         core_hung = 1'b0;
    int         rem       = 0;
    logic [7:0] core_res  = '0;

    function automatic logic [7:0] cbrt8(input logic [7:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(v)) r++;
        return 8'(r);
    endfunction

    always @(posedge clk) begin
        if (rst) rem <= 0;
        else if (bus.core_start_o) begin
            rem      <= core_hung ? 0 : core_len;
            core_res <= cbrt8(bus.core_x_o);
        end else if (rem > 0) rem <= rem - 1;
    end

    assign bus.core_busy_i = (rem != 0);
    assign bus.core_y_i    = (rem != 0) ? 8'hA5 : core_res;

    // Round-robin rule: first requester after the previous winner, wrapping.
    function automatic int model_grant(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        bus.req_i = '0;
        cyc();
        cyc();
        rst = 1'b0;
        last_m  = N - 1;
        prev_y  = '0;
        prev_id = '0;
    endtask

    task automatic serve(input logic [N-1:0] rq, input logic [8*N-1:0] xv, input int len,
                         input bit hung, input int exp_id, input logic [7:0] exp_y,
                         input bit exp_err);
        int w, exp_done, n_start, n_ack;
        bit seen;
        logic [7:0] opnd;
        w        = hung ? TIMEOUT : ((len + 1 < TIMEOUT) ? len + 1 : TIMEOUT);
        exp_done = w + 2;
        opnd     = xv[8*exp_id +: 8];
        cyc();
        core_len  = len;
        core_hung = hung;
        bus.req_i = rq;
        bus.x_bi  = xv;
        @(negedge clk);
        check("ack_grant", 32'(bus.ack_o), 32'(1) << exp_id);
        check("idle_busy", 32'(bus.busy_o), 0);
        check("idle_done", 32'(bus.done_o), 0);
        check("y_hold", 32'(bus.y_bo), 32'(prev_y));
        check("id_hold", 32'(bus.done_id_o), 32'(prev_id));
        n_start = 0;
        n_ack   = 0;
        seen    = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            cyc();
            bus.req_i = N'($urandom);
            bus.x_bi  = (8*N)'($urandom);
            @(negedge clk);
            if (c == 1) begin
                check("start_pulse", 32'(bus.core_start_o), 1);
                check("core_x", 32'(bus.core_x_o), 32'(opnd));
            end
            n_start += int'(bus.core_start_o);
            if (bus.ack_o != '0) n_ack++;
            if (bus.done_o) begin
                seen = 1'b1;
                check("done_cycle", c, exp_done);
                check("done_id", 32'(bus.done_id_o), exp_id);
                check("y", 32'(bus.y_bo), 32'(exp_y));
                check("err", 32'(bus.err_o), 32'(exp_err));
                check("core_x_held", 32'(bus.core_x_o), 32'(opnd));
                check("result_busy", 32'(bus.busy_o), 1);
            end
        end
        if (!seen) check("done_seen", 0, 1);
        check("start_count", n_start, 1);
        check("ack_outside_idle", n_ack, 0);
        bus.req_i = '0;
        prev_y  = exp_y;
        prev_id = IDW'(exp_id);
        last_m  = exp_id;
    endtask

    typedef struct {
        bit             rst_before;
        logic [N-1:0]   req;
        logic [8*N-1:0] x;
        int             len;
        bit             hung;
        int             exp_id;
        logic [7:0]     exp_y;
        bit             exp_err;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [N-1:0] q, input logic [8*N-1:0] x,
                                input int len, input bit hung, input int id,
                                input logic [7:0] y, input bit e);
        vec_t v;
        v.rst_before = r; v.req = q; v.x = x; v.len = len; v.hung = hung;
        v.exp_id = id; v.exp_y = y; v.exp_err = e;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [N-1:0]   rq;
        logic [8*N-1:0] xv;
        int len, id, nd;
        bit hung, e;

        rst       = 1'b1;
        bus.req_i = '0;
        bus.x_bi  = '0;

        tbl[0]  = mk(1, 4'b0001, 32'h0000001B, 4,  0, 0, 8'd3, 0);
        tbl[1]  = mk(1, 4'b1111, 32'hFF400800, 4,  0, 0, 8'd0, 0);
        tbl[2]  = mk(0, 4'b1111, 32'hFF400800, 4,  0, 1, 8'd2, 0);
        tbl[3]  = mk(0, 4'b1111, 32'hFF400800, 4,  0, 2, 8'd4, 0);
        tbl[4]  = mk(0, 4'b1111, 32'hFF400800, 4,  0, 3, 8'd6, 0);
        tbl[5]  = mk(1, 4'b0110, 32'h7D641B01, 3,  0, 1, 8'd3, 0);
        tbl[6]  = mk(0, 4'b0111, 32'h7D641B01, 3,  0, 2, 8'd4, 0);
        tbl[7]  = mk(0, 4'b0111, 32'h7D641B01, 3,  0, 0, 8'd1, 0);
        tbl[8]  = mk(0, 4'b0110, 32'h7D641B01, 3,  0, 1, 8'd3, 0);
        tbl[9]  = mk(0, 4'b0110, 32'h7D641B01, 3,  0, 2, 8'd4, 0);
        tbl[10] = mk(0, 4'b0100, 32'h001B0000, 4,  1, 2, 8'd0, 1);
        tbl[11] = mk(0, 4'b1000, 32'hC8000000, 4,  0, 3, 8'd5, 0);
        tbl[12] = mk(0, 4'b0001, 32'h000000D8, 14, 0, 0, 8'd6, 0);
        tbl[13] = mk(0, 4'b0010, 32'h00004000, 15, 0, 1, 8'd0, 1);
        tbl[14] = mk(0, 4'b1111, 32'h01081B40, 2,  0, 2, 8'd2, 0);
        tbl[15] = mk(0, 4'b1001, 32'h01081B40, 1,  0, 3, 8'd1, 0);
        tbl[16] = mk(0, 4'b1001, 32'h01081B40, 5,  0, 0, 8'd4, 0);

        do_reset();
        @(negedge clk);
        check("rst_ack", 32'(bus.ack_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_done_id", 32'(bus.done_id_o), 0);
        check("rst_y", 32'(bus.y_bo), 0);
        check("rst_err", 32'(bus.err_o), 0);
        check("rst_start", 32'(bus.core_start_o), 0);
        check("rst_core_x", 32'(bus.core_x_o), 0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst_before) do_reset();
            serve(tbl[i].req, tbl[i].x, tbl[i].len, tbl[i].hung,
                  tbl[i].exp_id, tbl[i].exp_y, tbl[i].exp_err);
        end

        // Reset asserted while the core is busy (WAIT_DONE).
        cyc();
        core_len  = 6;
        core_hung = 1'b0;
        bus.req_i = 4'b0010;
        bus.x_bi  = 32'h00007D00;
        @(negedge clk);
        check("rstseq_ack", 32'(bus.ack_o), 32'h2);
        cyc();
        bus.req_i = '0;
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rstseq_busy_before", 32'(bus.busy_o), 1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rstseq_busy", 32'(bus.busy_o), 0);
        check("rstseq_done", 32'(bus.done_o), 0);
        check("rstseq_y", 32'(bus.y_bo), 0);
        check("rstseq_core_x", 32'(bus.core_x_o), 0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            @(negedge clk);
            if (bus.done_o) nd++;
        end
        check("rstseq_no_done", nd, 0);
        last_m  = N - 1;
        prev_y  = '0;
        prev_id = '0;
        serve(4'b1111, 32'h01081B40, 3, 0, 0, 8'd4, 0);

        // Randomized transactions against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            do rq = N'($urandom); while (rq == '0);
            xv   = (8*N)'($urandom);
            len  = $urandom_range(1, 16);
            hung = ($urandom_range(0, 7) == 0);
            id   = model_grant(rq, last_m);
            e    = hung || (len + 1 >= TIMEOUT);
            serve(rq, xv, len, hung, id, e ? 8'd0 : cbrt8(xv[8*id +: 8]), e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
